axi4_lite_slave_regfile: RTL and testbench
==========================================

Name: axi4_lite_slave_regfile

Overview:
AXI4-Lite responder: a bank of 32-bit control registers written and read through the standard five channels. It is the completer end of the bus driven by the team's AXI4-Lite master. AW and W are accepted independently in either order. One write and one read may be outstanding at a time, each with full backpressure support on B and R. Register contents are also exported in parallel to the surrounding logic.

Parameters:
ADDR_WIDTH, 4, byte-address width of AWADDR/ARADDR
DATA_WIDTH, 32, data width; fixed at 32, word = 4 bytes
NUM_REGS, 4, number of registers; register i sits at byte address 4*i
RESET_VAL, 32'h0000_0000, reset value of every register

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  flattened register contents; register i occupies bits [32*i+31:32*i]

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Registers = RESET_VAL.
  - AWREADY, WREADY, ARREADY, BVALID and RVALID = 0.
  - BRESP, RRESP and RDATA = 0.
  - Both FSMs go to IDLE.
  - The READY outputs are flops. They rise at the first ACLK edge after ARESET falls.
- Handshake: a transfer occurs on the edge where VALID and READY are both 1.
- Address decode:
  - idx = addr >> 2.
  - addr[1:0] != 0 -> SLVERR (2'b10).
  - idx >= NUM_REGS -> DECERR (2'b11).
  - Otherwise OKAY (2'b00).
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW only -> latch addr, go to W_ADDR.
    - W only -> latch data, go to W_DATA.
    - Both in the same cycle -> go to W_RESP.
  - W_ADDR: AWREADY=0, WREADY=1. W handshake -> W_RESP.
  - W_DATA: AWREADY=1, WREADY=0. AW handshake -> W_RESP.
  - W_RESP: AWREADY=0, WREADY=0, BVALID=1, BRESP held stable. BREADY=1 -> W_IDLE, BVALID drops the next cycle.
- Write commit:
  - The register updates on the same edge that enters W_RESP.
  - Only an OKAY write commits; an SLVERR or DECERR write leaves every register unchanged.
  - Latency: BVALID is high in the cycle after the completing handshake.
  - If BREADY is held high, the next write is accepted 2 cycles after entry to W_RESP.
- Read FSM states:
  - R_IDLE: ARREADY=1. An AR handshake samples the register and the response into RDATA/RRESP, then -> R_DATA.
  - R_DATA: ARREADY=0, RVALID=1, RDATA/RRESP held stable. RREADY=1 -> R_IDLE.
- Read data on error: RDATA = 0 whenever RRESP != OKAY.
- Read latency: RVALID is high in the cycle after the AR handshake.
- Same-register read/write in one cycle: when a read samples the same register on the edge a write commits, the read returns the old value. The new value is visible to any AR handshake on a later edge.
- Independence: the write and read FSMs never block each other.
- reg_out: reflects the register flops directly, so it updates on the commit edge.
- ARESET asserted mid-transaction:
  - Immediate abort: VALIDs and READYs go to 0 and the FSMs go to IDLE.
  - A commit that has not yet occurred is lost.
- Backpressure: BVALID and RVALID each stay high, with stable payload, for any number of cycles until the matching READY is 1.

Test Plan:
- Write 0x00=1, 0x04=2, 0x08=3, 0x0C=4 with AW and W in the same cycle, BREADY=1 -> each BRESP=00, reg_out = {4,3,2,1}. Read back 0x00..0x0C -> RDATA 1,2,3,4, RRESP=00, RVALID the cycle after ARREADY&ARVALID.
- AW 0x04 issued, then W 0xDEADBEEF 3 cycles later -> AWREADY=0 and WREADY=1 while waiting. After the W handshake, reg1=0xDEADBEEF and BVALID=1 the next cycle. Repeat with W first, then AW.
- Misaligned AW 0x05 with W 0x1234 -> BRESP=10, registers unchanged. Read 0x06 -> RRESP=10, RDATA=0.
- With NUM_REGS=2: write to 0x08 -> BRESP=11, no commit. Read 0x0C -> RRESP=11, RDATA=0.
- Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID stay 1 and BRESP/RDATA stay stable; AWREADY/WREADY/ARREADY stay 0. Release -> one-cycle handshake, then back to IDLE.
- Reg2=0x11; same cycle: AR 0x08 and a commit of 0x22 to 0x08 -> RDATA=0x11, a following read returns 0x22. Separately, assert ARESET while in W_ADDR -> all outputs 0, reg_out all 0, first post-reset write completes normally.

Source files
------------

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite completer holding NUM_REGS control registers of 32 bits each.
// The write path (AW/W/B) and the read path (AR/R) are independent FSMs.
// Register contents are also exported flat on reg_out for the surrounding logic.
module axi4_lite_slave_regfile #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 32'h0000_0000
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  // Word index of a byte address (always 32 bits so it compares cleanly with ints)
  function automatic logic [31:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    word_idx = 32'(addr) >> 2;
  endfunction

  // Response for an address: misalignment wins over an out-of-range index
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
    if (addr[1:0] != 2'b00) begin
      decode_resp = RESP_SLVERR;
    end else if (word_idx(addr) >= 32'(NUM_REGS)) begin
      decode_resp = RESP_DECERR;
    end else begin
      decode_resp = RESP_OKAY;
    end
  endfunction

  // Write path state
  wstate_t                 wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   commit_addr;
  logic [DATA_WIDTH-1:0]   commit_data;

  // Read path state
  rstate_t                 rstate_q, rstate_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  // Register bank
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  assign aw_hs = AWVALID && awready_q;
  assign w_hs  = WVALID && wready_q;
  assign ar_hs = ARVALID && arready_q;

  // Write FSM next state: collect AW and W in either order, then commit and respond
  always_comb begin
    wstate_d    = wstate_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_addr = awaddr_q;
    commit_data = wdata_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = AWADDR;
          commit_data = WDATA;
        end else if (aw_hs) begin
          awaddr_d = AWADDR;
          wstate_d = W_ADDR;
        end else if (w_hs) begin
          wdata_d  = WDATA;
          wstate_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = WDATA;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = AWADDR;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) begin
      wstate_d = W_RESP;
      bresp_d  = decode_resp(commit_addr);
    end
    // Ready/valid flops follow the state being entered so they are glitch-free outputs
    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_DATA);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_ADDR);
    bvalid_d  = (wstate_d == W_RESP);
  end

  // Write FSM registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Register bank next value: only an error-free write lands in the addressed register
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit && (decode_resp(commit_addr) == RESP_OKAY)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (word_idx(commit_addr) == 32'(i)) begin
          regs_d[i] = commit_data;
        end
      end
    end
  end

  // Register bank flops
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read FSM next state: sample the pre-commit register value on the AR handshake
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rresp_d = decode_resp(ARADDR);
          rdata_d = '0;
          if (rresp_d == RESP_OKAY) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (word_idx(ARADDR) == 32'(i)) begin
                rdata_d = regs_q[i];
              end
            end
          end
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
  end

  // Read FSM registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile: a 4-register instance plus a
// 2-register instance driven by the same bus inputs (its handshakes stay in
// lockstep) so out-of-range decoding can be observed.
module tb_axi4_lite_slave_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   awaddr;
  logic         awvalid;
  logic [31:0]  wdata;
  logic         wvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic         arvalid;
  logic         rready;

  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] reg_out;

  logic         awready2, wready2, bvalid2, arready2, rvalid2;
  logic [1:0]   bresp2, rresp2;
  logic [31:0]  rdata2;
  logic [63:0]  reg_out2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_regfile #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4), .RESET_VAL(32'h0)) dut (
    .ACLK(clk), .ARESET(rst),
    .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
    .reg_out(reg_out)
  );

  axi4_lite_slave_regfile #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(2), .RESET_VAL(32'h0)) dut2 (
    .ACLK(clk), .ARESET(rst),
    .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready2),
    .WDATA(wdata), .WVALID(wvalid), .WREADY(wready2),
    .BRESP(bresp2), .BVALID(bvalid2), .BREADY(bready),
    .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready2),
    .RDATA(rdata2), .RRESP(rresp2), .RVALID(rvalid2), .RREADY(rready),
    .reg_out(reg_out2)
  );

  // Drive one write with AW and W together; report BVALID one cycle after the handshake
  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          output logic [1:0] resp, output logic [1:0] resp2, output logic lat_ok);
    int n;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(awready && wready) && n < 20);
    total++;
    if (!(awready && wready)) begin
      bad++;
      $display("FAIL write_hs_timeout addr=%h got awready=%b wready=%b want 1 1", a, awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    lat_ok = bvalid; resp = bresp; resp2 = bresp2;
    @(posedge clk); #1;
  endtask

  // Drive one read; report RVALID/RDATA one cycle after the handshake
  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic [31:0] d2, output logic [1:0] resp2, output logic lat_ok);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!arready && n < 20);
    total++;
    if (!arready) begin
      bad++;
      $display("FAIL read_hs_timeout addr=%h got arready=%b want 1", a, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    lat_ok = rvalid; d = rdata; resp = rresp; d2 = rdata2; resp2 = rresp2;
    @(posedge clk); #1;
  endtask

  // Present AW, W and AR together for a single shared handshake edge
  task automatic issue_both(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ra);
    int n;
    awaddr = wa; wdata = wd; araddr = ra;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(awready && wready && arready) && n < 20);
    total++;
    if (!(awready && wready && arready)) begin
      bad++;
      $display("FAIL both_hs_timeout got aw=%b w=%b ar=%b want 1 1 1", awready, wready, arready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_payload got bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    total++;
    if (reg_out !== 128'h0 || reg_out2 !== 64'h0) begin
      bad++;
      $display("FAIL reset_regs got %h %h want 0", reg_out, reg_out2);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++;
      $display("FAIL ready_before_edge got %b want 000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_edge got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r, r2, rr, rr2;
    logic lat;
    logic [31:0] d, d2;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), r, r2, lat);
      total++;
      if (r !== 2'b00 || lat !== 1'b1) begin
        bad++;
        $display("FAIL basic_write%0d got bresp=%b bvalid=%b want 00 1", i, r, lat);
      end
    end
    total++;
    if (reg_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      bad++;
      $display("FAIL basic_reg_out got %h want 00000004000000030000000200000001", reg_out);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), d, rr, d2, rr2, lat);
      total++;
      if (d !== 32'(i + 1) || rr !== 2'b00 || lat !== 1'b1) begin
        bad++;
        $display("FAIL basic_read%0d got rdata=%h rresp=%b rvalid=%b want %h 00 1", i, d, rr, lat, 32'(i + 1));
      end
    end
  endtask

  task automatic test_aw_first();
    awaddr = 4'h4; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({awready, wready, bvalid} !== 3'b010) begin
        bad++;
        $display("FAIL aw_first_wait%0d got aw/w/b=%b want 010", k, {awready, wready, bvalid});
      end
    end
    @(posedge clk); #1;
    wdata = 32'hDEAD_BEEF; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_out[63:32] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL aw_first_done got bvalid=%b bresp=%b reg1=%h want 1 00 deadbeef", bvalid, bresp, reg_out[63:32]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w_first();
    wdata = 32'hCAFE_F00D; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({awready, wready, bvalid} !== 3'b100) begin
        bad++;
        $display("FAIL w_first_wait%0d got aw/w/b=%b want 100", k, {awready, wready, bvalid});
      end
    end
    @(posedge clk); #1;
    awaddr = 4'hC; awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_out[127:96] !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL w_first_done got bvalid=%b bresp=%b reg3=%h want 1 00 cafef00d", bvalid, bresp, reg_out[127:96]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_slverr();
    logic [1:0] r, r2, rr, rr2;
    logic lat;
    logic [31:0] d, d2;
    do_write(4'h5, 32'h0000_1234, r, r2, lat);
    total++;
    if (r !== 2'b10 || lat !== 1'b1) begin
      bad++;
      $display("FAIL slverr_bresp got %b bvalid=%b want 10 1", r, lat);
    end
    total++;
    if (reg_out !== {32'hCAFE_F00D, 32'd3, 32'hDEAD_BEEF, 32'd1}) begin
      bad++;
      $display("FAIL slverr_no_commit got %h want cafef00d00000003deadbeef00000001", reg_out);
    end
    do_read(4'h6, d, rr, d2, rr2, lat);
    total++;
    if (rr !== 2'b10 || d !== 32'h0) begin
      bad++;
      $display("FAIL slverr_read got rresp=%b rdata=%h want 10 00000000", rr, d);
    end
  endtask

  task automatic test_decerr();
    logic [1:0] r, r2, rr, rr2;
    logic lat;
    logic [31:0] d, d2;
    do_write(4'h8, 32'h0000_0055, r, r2, lat);
    total++;
    if (r2 !== 2'b11 || reg_out2 !== {32'hDEAD_BEEF, 32'd1}) begin
      bad++;
      $display("FAIL decerr_write got bresp=%b regs=%h want 11 deadbeef00000001", r2, reg_out2);
    end
    total++;
    if (r !== 2'b00 || reg_out[95:64] !== 32'h55) begin
      bad++;
      $display("FAIL inrange_write got bresp=%b reg2=%h want 00 00000055", r, reg_out[95:64]);
    end
    do_read(4'hC, d, rr, d2, rr2, lat);
    total++;
    if (rr2 !== 2'b11 || d2 !== 32'h0) begin
      bad++;
      $display("FAIL decerr_read got rresp=%b rdata=%h want 11 00000000", rr2, d2);
    end
    total++;
    if (rr !== 2'b00 || d !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL inrange_read got rresp=%b rdata=%h want 00 cafef00d", rr, d);
    end
  endtask

  task automatic test_backpressure();
    bready = 1'b0; rready = 1'b0;
    issue_both(4'h0, 32'hA5A5_0000, 4'h4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000 || bresp !== 2'b00 ||
          rresp !== 2'b00 || rdata !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL backpressure%0d got b/r/aw/w/ar=%b bresp=%b rresp=%b rdata=%h want 11000 00 00 deadbeef",
                 k, {bvalid, rvalid, awready, wready, arready}, bresp, rresp, rdata);
      end
    end
    total++;
    if (reg_out[31:0] !== 32'hA5A5_0000) begin
      bad++;
      $display("FAIL backpressure_commit got reg0=%h want a5a50000", reg_out[31:0]);
    end
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    total++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      bad++;
      $display("FAIL backpressure_release got b/r/aw/w/ar=%b want 00111", {bvalid, rvalid, awready, wready, arready});
    end
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
  endtask

  task automatic test_same_cycle();
    logic [1:0] r, r2, rr, rr2;
    logic lat;
    logic [31:0] d, d2;
    do_write(4'h8, 32'h11, r, r2, lat);
    total++;
    if (r !== 2'b00 || reg_out[95:64] !== 32'h11) begin
      bad++;
      $display("FAIL same_setup got bresp=%b reg2=%h want 00 00000011", r, reg_out[95:64]);
    end
    bready = 1'b1; rready = 1'b1;
    issue_both(4'h8, 32'h22, 4'h8);
    @(negedge clk);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h11 || reg_out[95:64] !== 32'h22) begin
      bad++;
      $display("FAIL same_cycle got rvalid=%b rdata=%h reg2=%h want 1 00000011 00000022", rvalid, rdata, reg_out[95:64]);
    end
    @(posedge clk); #1;
    do_read(4'h8, d, rr, d2, rr2, lat);
    total++;
    if (d !== 32'h22 || rr !== 2'b00) begin
      bad++;
      $display("FAIL same_followup got rdata=%h rresp=%b want 00000022 00", d, rr);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r, r2;
    logic lat;
    awaddr = 4'h4; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({awready, wready} !== 2'b01) begin
      bad++;
      $display("FAIL mid_w_addr got aw/w=%b want 01", {awready, wready});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 ||
        rresp !== 2'b00 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs got ctrl=%b bresp=%b rresp=%b rdata=%h want 0",
               {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata);
    end
    total++;
    if (reg_out !== 128'h0 || reg_out2 !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset_regs got %h %h want 0", reg_out, reg_out2);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_write(4'h4, 32'h77, r, r2, lat);
    total++;
    if (r !== 2'b00 || lat !== 1'b1 || reg_out !== {32'h0, 32'h0, 32'h77, 32'h0}) begin
      bad++;
      $display("FAIL post_reset_write got bresp=%b bvalid=%b regs=%h want 00 1 ...77 in reg1", r, lat, reg_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_first();
    test_w_first();
    test_slverr();
    test_decerr();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
